microcode_loader: RTL and testbench

//  Writer side of the CPU microcode control store. Receives a byte stream over a

---
 rtl/microcode_loader.sv | 99 +++++++++
 tb/tb_microcode_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_loader.sv
// rtl/microcode_loader.sv - byte stream to 64-bit control-store word writer
module microcode_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              r,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  // Address of the final word of a full load; the loader never advances past it.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t     state;
  state_t     next;
  logic [2:0] cnt;
  logic       accept;

  // State register; reset forces IDLE regardless of any other input.
  always_ff @(posedge clk) begin
    if (!r) state <= S_IDLE;
    else    state <= next;
  end

  // Next-state and outputs; abort wins over an 8th byte or a pending write.
  always_comb begin
    next       = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next = S_FILL;
      end
      S_FILL: begin
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        byte_ready = !abort;
        accept     = byte_valid && !abort;
        if (abort)                      next = S_IDLE;
        else if (accept && cnt == 3'd7) next = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        wr_en    = !abort;
        if (abort)              next = S_IDLE;
        else if (wr_addr == LAST) next = S_DONE;
        else                    next = S_FILL;
      end
      S_DONE: begin
        cpu_hold = 1'b1;
        done     = 1'b1;
        next     = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // Datapath: big-endian byte packing, byte count, write address, abort pulse.
  always_ff @(posedge clk) begin
    if (!r) begin
      wr_addr <= '0;
      wr_data <= '0;
      cnt     <= 3'd0;
      aborted <= 1'b0;
    end else begin
      aborted <= abort && (state == S_FILL || state == S_WRITE);
      if (state == S_IDLE && start) begin
        wr_addr <= '0;
        cnt     <= 3'd0;
      end
      if (accept) begin
        wr_data <= {wr_data[WORD_W-9:0], byte_in};
        cnt     <= cnt + 3'd1;
      end
      if (state == S_WRITE && !abort && wr_addr != LAST)
        wr_addr <= wr_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_microcode_loader.sv
// tb/tb_microcode_loader.sv - directed bench for microcode_loader
module tb_microcode_loader;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic        rdy4, we4, hold4, busy4, done4, ab4;
  logic [11:0] addr4;
  logic [63:0] data4;
  logic        rdy1, we1, hold1, busy1, done1, ab1;
  logic [11:0] addr1;
  logic [63:0] data1;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];
  logic [11:0] aq[$];
  int          done_cnt = 0;
  int          ready_viol = 0;

  always #5 clk = ~clk;

  microcode_loader #(.ADDR_W(12), .DEPTH(4)) dut4 (
    .clk(clk), .r(r), .start(start), .abort(abort), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy4), .wr_en(we4), .wr_addr(addr4),
    .wr_data(data4), .cpu_hold(hold4), .busy(busy4), .done(done4), .aborted(ab4)
  );

  microcode_loader #(.ADDR_W(12), .DEPTH(1)) dut1 (
    .clk(clk), .r(r), .start(start), .abort(abort), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(rdy1), .wr_en(we1), .wr_addr(addr1),
    .wr_data(data1), .cpu_hold(hold1), .busy(busy1), .done(done1), .aborted(ab1)
  );

  // Scoreboard of DEPTH=4 writes, sampled mid-cycle
  always @(negedge clk) begin
    if (we4 === 1'b1) begin
      wq.push_back(data4);
      aq.push_back(addr4);
      if (rdy4 !== 1'b0) ready_viol++;
    end
    if (done4 === 1'b1) done_cnt++;
  end

  typedef struct {
    logic        r, st, ab, bv;
    logic [7:0]  b;
    logic        rdy, we;
    logic [11:0] addr;
    logic [63:0] data;
    logic        busy, hold, done, abrt;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic rr, st, ab, bv, input logic [7:0] b,
                              input logic rdy, we, input logic [11:0] addr,
                              input logic [63:0] data, input logic bs, hd, dn, at);
    vec_t v;
    v.r = rr; v.st = st; v.ab = ab; v.bv = bv; v.b = b;
    v.rdy = rdy; v.we = we; v.addr = addr; v.data = data;
    v.busy = bs; v.hold = hd; v.done = dn; v.abrt = at;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    r = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 r = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_sb();
    wq.delete(); aq.delete();
    done_cnt = 0; ready_viol = 0;
  endtask

  // Offer n bytes to the DEPTH=4 loader; optional gaps and one stray start pulse
  task automatic stream(input int n, input int base, input bit a5, input bit gaps,
                        input int pulse_idx);
    int idx = 0;
    int cyc = 0;
    bit pulsed = 1'b0;
    bit acc;
    while (idx < n && cyc < 2000) begin
      byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_in    = a5 ? 8'hA5 : 8'(base + idx);
      start      = (!pulsed && idx == pulse_idx);
      if (start) pulsed = 1'b1;
      @(negedge clk);
      acc = byte_valid && rdy4;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    chk("stream_complete", 64'(idx), 64'(n));
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({nm, "_hold_in_done"}, 64'(hold4), 64'd1);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, 64'(done4), 64'd0);
      chk({nm, "_hold_dropped"}, 64'(hold4), 64'd0);
      chk({nm, "_busy_dropped"}, 64'(busy4), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_addrs(input string nm);
    chk({nm, "_nwrites"}, 64'(aq.size()), 64'd4);
    for (int i = 0; i < aq.size() && i < 4; i++)
      chk($sformatf("%s_addr%0d", nm, i), 64'(aq[i]), 64'(i));
  endtask

  initial begin
    // 1: full DEPTH=4 load, valid held high
    do_reset();
    @(negedge clk);
    chk("reset_ready", 64'(rdy4), 64'd0);
    chk("reset_busy", 64'(busy4), 64'd0);
    chk("reset_hold", 64'(hold4), 64'd0);
    chk("reset_addr", 64'(addr4), 64'd0);
    chk("reset_data", data4, 64'd0);
    chk("reset_done_aborted", 64'({done4, ab4, we4}), 64'd0);
    @(posedge clk); #1;
    clear_sb();
    pulse_start();
    stream(32, 0, 1'b0, 1'b0, -1);
    wait_done("t1");
    chk_addrs("t1");
    if (wq.size() == 4) begin
      chk("t1_word0", wq[0], 64'h0001020304050607);
      chk("t1_word3", wq[3], 64'h18191A1B1C1D1E1F);
    end
    chk("t1_done_count", 64'(done_cnt), 64'd1);

    // 2: 0xA5 stream with random valid gaps
    clear_sb();
    pulse_start();
    stream(32, 0, 1'b1, 1'b1, -1);
    wait_done("t2");
    chk_addrs("t2");
    for (int i = 0; i < wq.size(); i++)
      chk($sformatf("t2_word%0d", i), wq[i], 64'hA5A5A5A5A5A5A5A5);
    chk("t2_ready_on_write", 64'(ready_viol), 64'd0);

    // 3: abort coincident with the 8th byte of word 2
    clear_sb();
    pulse_start();
    stream(23, 0, 1'b0, 1'b0, -1);
    byte_valid = 1'b1; byte_in = 8'h17; abort = 1'b1;
    @(negedge clk);
    chk("t3_ready_under_abort", 64'(rdy4), 64'd0);
    chk("t3_no_wr_en", 64'(we4), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    chk("t3_aborted_pulse", 64'(ab4), 64'd1);
    chk("t3_idle_busy", 64'(busy4), 64'd0);
    chk("t3_idle_hold", 64'(hold4), 64'd0);
    @(negedge clk);
    chk("t3_aborted_one_cycle", 64'(ab4), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_writes", 64'(wq.size()), 64'd2);
    chk("t3_no_done", 64'(done_cnt), 64'd0);

    // 4: start pulsed mid-FILL has no effect
    clear_sb();
    pulse_start();
    stream(32, 0, 1'b0, 1'b0, 12);
    wait_done("t4");
    chk_addrs("t4");
    if (wq.size() == 4) chk("t4_word1", wq[1], 64'h08090A0B0C0D0E0F);

    // 5: reset mid-FILL with valid high, then a clean load
    clear_sb();
    pulse_start();
    stream(5, 0, 1'b0, 1'b0, -1);
    r = 1'b0; byte_valid = 1'b1; byte_in = 8'h55;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_ready", 64'(rdy4), 64'd0);
    chk("t5_addr_data", {52'd0, addr4} | data4, 64'd0);
    chk("t5_flags", 64'({we4, hold4, busy4, done4, ab4}), 64'd0);
    @(posedge clk); #1;
    r = 1'b1; byte_valid = 1'b0;
    clear_sb();
    pulse_start();
    stream(32, 8'h40, 1'b0, 1'b0, -1);
    wait_done("t5");
    chk_addrs("t5");
    if (wq.size() == 4) chk("t5_word0", wq[0], 64'h4041424344454647);

    // 6: DEPTH=1 table, including start+abort in IDLE and a 9th byte offered
    do_reset();
    vt[0]  = mk(1,1,1,0,8'h00, 0,0,12'h0,64'h0,                0,0,0,0);
    vt[1]  = mk(1,0,0,1,8'h81, 1,0,12'h0,64'h0,                1,1,0,0);
    vt[2]  = mk(1,0,0,1,8'h82, 1,0,12'h0,64'h81,               1,1,0,0);
    vt[3]  = mk(1,0,0,1,8'h83, 1,0,12'h0,64'h8182,             1,1,0,0);
    vt[4]  = mk(1,0,0,1,8'h84, 1,0,12'h0,64'h818283,           1,1,0,0);
    vt[5]  = mk(1,0,0,1,8'h85, 1,0,12'h0,64'h81828384,         1,1,0,0);
    vt[6]  = mk(1,0,0,1,8'h86, 1,0,12'h0,64'h8182838485,       1,1,0,0);
    vt[7]  = mk(1,0,0,1,8'h87, 1,0,12'h0,64'h818283848586,     1,1,0,0);
    vt[8]  = mk(1,0,0,1,8'h88, 1,0,12'h0,64'h81828384858687,   1,1,0,0);
    vt[9]  = mk(1,0,0,1,8'h99, 0,1,12'h0,64'h8182838485868788, 1,1,0,0);
    vt[10] = mk(1,0,1,1,8'h99, 0,0,12'h0,64'h8182838485868788, 0,1,1,0);
    vt[11] = mk(1,0,0,1,8'h99, 0,0,12'h0,64'h8182838485868788, 0,0,0,0);
    vt[12] = mk(1,0,0,0,8'h00, 0,0,12'h0,64'h8182838485868788, 0,0,0,0);
    for (int i = 0; i < 13; i++) begin
      r = vt[i].r; start = vt[i].st; abort = vt[i].ab;
      byte_valid = vt[i].bv; byte_in = vt[i].b;
      @(negedge clk);
      chk($sformatf("t6[%0d].ready", i), 64'(rdy1), 64'(vt[i].rdy));
      chk($sformatf("t6[%0d].wr_en", i), 64'(we1), 64'(vt[i].we));
      chk($sformatf("t6[%0d].addr", i), 64'(addr1), 64'(vt[i].addr));
      chk($sformatf("t6[%0d].data", i), data1, vt[i].data);
      chk($sformatf("t6[%0d].busy", i), 64'(busy1), 64'(vt[i].busy));
      chk($sformatf("t6[%0d].hold", i), 64'(hold1), 64'(vt[i].hold));
      chk($sformatf("t6[%0d].done", i), 64'(done1), 64'(vt[i].done));
      chk($sformatf("t6[%0d].aborted", i), 64'(ab1), 64'(vt[i].abrt));
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
